// File: rtl/block_stream_gen.sv
// -----------------------------------------------------------------------------
// block_stream_gen
// Transmit side of the begin/end keyword character stream. Accepts token
// commands (BEGIN, END, WORD, SPACE) over a valid/ready handshake. Each token
// is sent as a sequence of 8-bit ASCII characters, one per accepted output beat.
// The block also tracks the nesting depth of committed tokens.
//
// Parameters:
//   DEPTH_W  width of the nesting-depth counter (max depth 2**DEPTH_W-1)
//   UPPER    1: uppercase letters, 0: lowercase letters
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   cmd_valid  command present
//   cmd        00 BEGIN, 01 END, 10 WORD, 11 SPACE
//   cmd_ready  command can be accepted (IDLE and not in reset)
//   out_valid  out_char is valid
//   out_char   ASCII character
//   out_ready  downstream accepts out_char this cycle
//   depth      committed nesting depth
//   balanced   depth==0 && !err
//   err        sticky END-underflow / BEGIN-overflow flag
//
// Optional feature macro: BSG_UNDERFLOW_GUARD_EN
//   When defined, an END accepted at depth 0 is consumed silently. No
//   characters are emitted, and err/depth are left unchanged.
// -----------------------------------------------------------------------------
module block_stream_gen #(
    parameter int DEPTH_W = 8,
    parameter bit UPPER   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    output logic               cmd_ready,
    output logic               out_valid,
    output logic [7:0]         out_char,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err
);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    localparam logic [1:0]         CMD_BEGIN = 2'b00;
    localparam logic [1:0]         CMD_END   = 2'b01;
    localparam logic [1:0]         CMD_WORD  = 2'b10;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t             state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [2:0]         idx_q, idx_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               drop_end;

    // Character ROM. Letters are stored in lowercase. Uppercase is derived by
    // clearing bit 5. The space delimiter is never altered.
    function automatic logic [7:0] rom_char(input logic [1:0] c, input logic [2:0] i);
        logic [7:0] ch;
        ch = 8'h20;
        case (c)
            CMD_BEGIN: begin
                case (i)
                    3'd0:    ch = 8'h62;
                    3'd1:    ch = 8'h65;
                    3'd2:    ch = 8'h67;
                    3'd3:    ch = 8'h69;
                    3'd4:    ch = 8'h6E;
                    default: ch = 8'h20;
                endcase
            end
            CMD_END: begin
                case (i)
                    3'd0:    ch = 8'h65;
                    3'd1:    ch = 8'h6E;
                    3'd2:    ch = 8'h64;
                    default: ch = 8'h20;
                endcase
            end
            CMD_WORD: begin
                if (i == 3'd0) ch = 8'h78;
            end
            default: ch = 8'h20;
        endcase
        if (UPPER && (ch != 8'h20)) ch = ch & 8'hDF;
        return ch;
    endfunction

    // Index of the closing space for each token.
    function automatic logic [2:0] last_idx(input logic [1:0] c);
        case (c)
            CMD_BEGIN: last_idx = 3'd5;
            CMD_END:   last_idx = 3'd3;
            CMD_WORD:  last_idx = 3'd1;
            default:   last_idx = 3'd0;
        endcase
    endfunction

`ifdef BSG_UNDERFLOW_GUARD_EN
    assign drop_end = (cmd == CMD_END) && (depth_q == '0);
`else
    assign drop_end = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_BEGIN;
            idx_q   <= 3'd0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Next state. The depth commit happens only when the final space of a
    // token is accepted, so an abandoned token never changes depth.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        depth_d = depth_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // A dropped END is consumed here and the block stays in IDLE.
                if (cmd_valid && !drop_end) begin
                    cmd_d   = cmd;
                    idx_d   = 3'd0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (idx_q == last_idx(cmd_q)) begin
                        state_d = S_IDLE;
                        if (cmd_q == CMD_BEGIN) begin
                            if (depth_q == DEPTH_MAX) err_d = 1'b1;
                            else                      depth_d = depth_q + 1'b1;
                        end else if (cmd_q == CMD_END) begin
                            if (depth_q == '0) err_d = 1'b1;
                            else               depth_d = depth_q - 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs. cmd_ready is gated by reset so that it reads 0 for the
    // whole time reset is asserted.
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && !reset;
        out_valid = (state_q == S_EMIT);
        out_char  = (state_q == S_EMIT) ? rom_char(cmd_q, idx_q) : 8'h20;
        depth     = depth_q;
        err       = err_q;
        balanced  = (depth_q == '0) && !err_q;
    end

endmodule
